// File: rtl/id_ds_buffer_pkg.sv
// Shared payload types for the decode -> data-select buffer.
// Consumed by id_ds_buffer and fifo2_bundle.
package basicparams;

    typedef logic [31:0] UIntX;
    typedef logic [31:0] InstPc;
    typedef logic [31:0] Inst;
    typedef logic [15:0] IId;
    typedef logic [15:0] Ctrl;

    localparam int ID_DS_DEPTH = 2;

    typedef struct packed {
        InstPc pc;
        Inst   inst;
        IId    instId;
        Ctrl   ctrl;
        UIntX  immI;
        UIntX  immS;
        UIntX  immB;
        UIntX  immJ;
        UIntX  immU;
        UIntX  immZ;
    } IdDsBundle;

endpackage

// File: rtl/id_ds_buffer_fifo2_bundle.sv
// Two-entry pointer/count FIFO of IdDsBundle with flush.
// o_ready is registered and depends only on occupancy.
module fifo2_bundle
    import basicparams::*;
(
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  logic      i_pop,
    input  logic      i_flush,
    input  IdDsBundle i_wdata,
    output IdDsBundle o_rdata,
    output logic [1:0] o_count,
    output logic      o_ready
);

    logic       r_rdPtr;
    logic       r_wrPtr;
    logic [1:0] r_count;
    logic       r_ready;
    IdDsBundle  r_mem [0:ID_DS_DEPTH-1];

    logic       w_doPush;
    logic       w_doPop;
    logic [1:0] w_countNext;

    assign w_doPush = i_push && (r_count != 2'd2);
    assign w_doPop  = i_pop && (r_count != 2'd0);

    always_comb begin
        w_countNext = r_count;
        if (w_doPush && !w_doPop) begin
            w_countNext = r_count + 2'd1;
        end else if (w_doPop && !w_doPush) begin
            w_countNext = r_count - 2'd1;
        end
    end

    // Reset outranks flush; both empty the buffer, only reset drops ready.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_count <= 2'd0;
            r_ready <= 1'b0;
        end else if (i_flush) begin
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_count <= 2'd0;
            r_ready <= 1'b1;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= ~r_wrPtr;
            end
            if (w_doPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= w_countNext;
            r_ready <= (w_countNext != 2'd2);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_flush && w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign o_ready = r_ready;

endmodule

// File: rtl/id_ds_buffer.sv
// Decode -> data-select elastic buffer (depth 2, strict FIFO, flushable).
// Define ID_DS_BYPASS_EN to pass id_* straight to ds_* when the buffer is empty.
module id_ds_buffer
    import basicparams::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  id_valid,
    output logic  id_ready,
    input  InstPc id_pc,
    input  Inst   id_inst,
    input  IId    id_inst_id,
    input  Ctrl   id_ctrl,
    input  UIntX  id_imm_i,
    input  UIntX  id_imm_s,
    input  UIntX  id_imm_b,
    input  UIntX  id_imm_j,
    input  UIntX  id_imm_u,
    input  UIntX  id_imm_z,
    output logic  ds_valid,
    output InstPc ds_pc,
    output Inst   ds_inst,
    output IId    ds_inst_id,
    output Ctrl   ds_ctrl,
    output UIntX  ds_imm_i,
    output UIntX  ds_imm_s,
    output UIntX  ds_imm_b,
    output UIntX  ds_imm_j,
    output UIntX  ds_imm_u,
    output UIntX  ds_imm_z,
    input  logic  dh_stall_flg,
    input  logic  flush
);

`ifdef ID_DS_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    IdDsBundle  w_inBundle;
    IdDsBundle  w_headBundle;
    IdDsBundle  w_present;
    logic [1:0] w_count;
    logic       w_ready;
    logic       w_bypass;
    logic       w_dsValid;
    logic       w_push;
    logic       w_pop;
    logic       w_fifoPush;
    logic       w_fifoPop;

    always_comb begin
        w_inBundle.pc     = id_pc;
        w_inBundle.inst   = id_inst;
        w_inBundle.instId = id_inst_id;
        w_inBundle.ctrl   = id_ctrl;
        w_inBundle.immI   = id_imm_i;
        w_inBundle.immS   = id_imm_s;
        w_inBundle.immB   = id_imm_b;
        w_inBundle.immJ   = id_imm_j;
        w_inBundle.immU   = id_imm_u;
        w_inBundle.immZ   = id_imm_z;
    end

    // The bypass beat also needs id_ready so decode and data-select agree it was handed over.
    assign w_bypass  = BYPASS_EN && (w_count == 2'd0);
    assign w_dsValid = rst_n && !flush &&
                       ((w_count != 2'd0) || (w_bypass && id_valid && w_ready));
    assign w_present = w_bypass ? w_inBundle : w_headBundle;

    assign w_push     = id_valid && w_ready && !flush;
    assign w_pop      = w_dsValid && !dh_stall_flg;
    assign w_fifoPush = w_push && !(w_bypass && w_pop);
    assign w_fifoPop  = w_pop && !w_bypass;

    fifo2_bundle u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_fifoPush),
        .i_pop   (w_fifoPop),
        .i_flush (flush),
        .i_wdata (w_inBundle),
        .o_rdata (w_headBundle),
        .o_count (w_count),
        .o_ready (w_ready)
    );

    assign id_ready   = w_ready;
    assign ds_valid   = w_dsValid;
    assign ds_pc      = w_present.pc;
    assign ds_inst    = w_present.inst;
    assign ds_inst_id = w_present.instId;
    assign ds_ctrl    = w_present.ctrl;
    assign ds_imm_i   = w_present.immI;
    assign ds_imm_s   = w_present.immS;
    assign ds_imm_b   = w_present.immB;
    assign ds_imm_j   = w_present.immJ;
    assign ds_imm_u   = w_present.immU;
    assign ds_imm_z   = w_present.immZ;

endmodule
